// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the multiplexed hex digit scanner.
package hex_scan_pkg;

   localparam int MAX_DIGITS = 8;
   localparam int IDX_MAX_W  = 3;
   localparam int VAL_W      = 4 * MAX_DIGITS;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

   function automatic logic [MAX_DIGITS-1:0] sel_onehot_n(input logic [IDX_MAX_W-1:0] idx);
      logic [MAX_DIGITS-1:0] sel;
      sel      = '1;
      sel[idx] = 1'b0;
      return sel;
   endfunction

   // Nibbles above the real digit count arrive zero-extended, so they never block suppression.
   function automatic logic lz_suppress(input logic [VAL_W-1:0] value,
                                        input logic [IDX_MAX_W-1:0] idx);
      logic upper_zero;
      upper_zero = 1'b1;
      for (int d = 0; d < MAX_DIGITS; d++) begin
         if (d >= int'(idx) && value[4*d +: 4] != 4'h0) upper_zero = 1'b0;
      end
      return (idx != '0) && upper_zero;
   endfunction

endpackage

// File: rtl/hex_digit_scanner_timer.sv
// Slot timer: counts clk cycles within a digit slot and tracks the BLANK/ON phase.
// tick_o and in_blank_o describe the cycle after the coming edge so the parent can register outputs.
module scan_slot_timer
   import hex_scan_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500,
   localparam int TICK_W      = $clog2(REFRESH_DIV)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [TICK_W-1:0] tick_o,
   output logic              slot_end_o,
   output logic              in_blank_o
);

   localparam scan_state_t RESET_STATE = (BLANK_CYCLES == 0) ? ON : BLANK;

   logic [TICK_W-1:0] tick_q, tick_d;
   scan_state_t       state_q, state_d;
   logic              wrap;
   logic              blank_d;

   assign wrap   = (tick_q == TICK_W'(REFRESH_DIV - 1));
   assign tick_d = wrap ? '0 : tick_q + TICK_W'(1);

   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_d = 1'b0;
   end else begin : g_blank
      assign blank_d = (tick_d < TICK_W'(BLANK_CYCLES));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q  <= '0;
         state_q <= RESET_STATE;
      end else begin
         tick_q  <= tick_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BLANK: if (!blank_d) state_d = ON;
         ON:    if (blank_d)  state_d = BLANK;
      endcase
   end

   always_comb begin
      tick_o     = tick_d;
      slot_end_o = wrap;
      in_blank_o = (state_d == BLANK);
   end

endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes a packed hex value onto one nibble bus plus active-low digit enables,
// committing new data only at frame boundaries.
module hex_digit_scanner
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    lz_en,
   output logic [3:0]              digit_val,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_start,
   output logic                    pending
);

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int TICK_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic                    pending_q, pending_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [3:0]              digit_val_q, digit_val_d;
   logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
   logic                    frame_start_q, frame_start_d;

   logic [TICK_W-1:0]       tick_next;
   logic                    slot_end;
   logic                    blank_next;
   logic                    commit;
   logic [IDX_MAX_W-1:0]    idx_ext;

   scan_slot_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_o     (tick_next),
      .slot_end_o (slot_end),
      .in_blank_o (blank_next)
   );

   assign commit = slot_end && (idx_q == IDX_LAST);

   // A load landing on the commit edge bypasses the shadow so it is not deferred a whole frame.
   always_comb begin
      idx_d     = idx_q;
      shadow_d  = load ? data_in : shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (slot_end) idx_d = commit ? '0 : idx_q + IDX_W'(1);
      if (commit) begin
         if (load)           active_d = data_in;
         else if (pending_q) active_d = shadow_q;
         pending_d = 1'b0;
      end else if (load) begin
         pending_d = 1'b1;
      end
   end

   // Output registers are loaded from next-state values so the nibble, enables and
   // frame pulse all line up with the first cycle of each slot.
   always_comb begin
      idx_ext       = IDX_MAX_W'(idx_d);
      digit_val_d   = active_d[4*idx_d +: 4];
      frame_start_d = (tick_next == '0) && (idx_d == '0);
      if (blank_next || (lz_en && lz_suppress(VAL_W'(active_d), idx_ext)))
         digit_sel_d = '1;
      else
         digit_sel_d = NUM_DIGITS'(sel_onehot_n(idx_ext));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         active_q      <= '0;
         pending_q     <= 1'b0;
         idx_q         <= '0;
         digit_val_q   <= '0;
         digit_sel_q   <= '1;
         frame_start_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         idx_q         <= idx_d;
         digit_val_q   <= digit_val_d;
         digit_sel_q   <= digit_sel_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign digit_val   = digit_val_q;
   assign digit_sel   = digit_sel_q;
   assign frame_start = frame_start_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with 4 digits, 4-cycle slots and 1 blank cycle.
module tb_hex_digit_scanner;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] data_in;
   logic        lz_en;
   logic [3:0]  digit_val;
   logic [3:0]  digit_sel;
   logic        frame_start;
   logic        pending;

   int checks = 0;
   int errors = 0;
   int n;

   hex_digit_scanner #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (4),
      .BLANK_CYCLES (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .data_in     (data_in),
      .lz_en       (lz_en),
      .digit_val   (digit_val),
      .digit_sel   (digit_sel),
      .frame_start (frame_start),
      .pending     (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advances negedge by negedge until frame_start is seen; cnt is the number of cycles waited.
   task automatic wait_frame_start(output int cnt);
      logic found;
      found = 1'b0;
      cnt   = 0;
      while (!found && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (frame_start === 1'b1) found = 1'b1;
      end
      chk("frame_start_seen", {31'd0, found}, 32'd1);
   endtask

   // Called in the first cycle of a frame; walks all 16 cycles and ends in the last one.
   task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] on_mask);
      logic [3:0] exp_sel;
      for (int s = 0; s < 4; s++) begin
         for (int t = 0; t < 4; t++) begin
            if (s != 0 || t != 0) @(negedge clk);
            exp_sel = 4'hF;
            if (t != 0 && on_mask[s]) exp_sel[s] = 1'b0;
            chk({tag, "_val"}, {28'd0, digit_val}, {28'd0, val[4*s +: 4]});
            chk({tag, "_sel"}, {28'd0, digit_sel}, {28'd0, exp_sel});
            chk({tag, "_fs"}, {31'd0, frame_start}, (s == 0 && t == 0) ? 32'd1 : 32'd0);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      load    = 1'b0;
      data_in = 16'h0000;
      lz_en   = 1'b0;

      // Reset state and first frame after release
      repeat (2) @(negedge clk);
      chk("rst_sel", {28'd0, digit_sel}, 32'hF);
      chk("rst_val", {28'd0, digit_val}, 32'h0);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      chk("rst_pending", {31'd0, pending}, 32'd0);
      rst_n = 1'b1;
      chk("rel_sel", {28'd0, digit_sel}, 32'hF);
      @(negedge clk);
      chk("slot0_t1_sel", {28'd0, digit_sel}, 32'hE);
      load    = 1'b1;
      data_in = 16'h1A3F;
      @(negedge clk);
      load = 1'b0;
      chk("load_pending", {31'd0, pending}, 32'd1);
      chk("old_val", {28'd0, digit_val}, 32'h0);
      wait_frame_start(n);
      chk("first_fs_delay", n, 32'd14);
      chk("commit_pending", {31'd0, pending}, 32'd0);
      check_frame("f1A3F", 16'h1A3F, 4'b1111);

      // Leading-zero suppression
      lz_en = 1'b1;
      repeat (2) @(negedge clk);
      load    = 1'b1;
      data_in = 16'h0040;
      @(negedge clk);
      load = 1'b0;
      wait_frame_start(n);
      check_frame("f0040", 16'h0040, 4'b0011);
      repeat (2) @(negedge clk);
      load    = 1'b1;
      data_in = 16'h0000;
      @(negedge clk);
      load = 1'b0;
      wait_frame_start(n);
      check_frame("f0000", 16'h0000, 4'b0001);
      wait_frame_start(n);
      repeat (9) @(negedge clk);
      chk("lz_on_sel", {28'd0, digit_sel}, 32'hF);
      lz_en = 1'b0;
      @(negedge clk);
      chk("lz_off_sel", {28'd0, digit_sel}, 32'hB);

      // Mid-frame load waits for the next frame
      wait_frame_start(n);
      repeat (5) @(negedge clk);
      load    = 1'b1;
      data_in = 16'h1111;
      @(negedge clk);
      load = 1'b0;
      chk("mid_pending", {31'd0, pending}, 32'd1);
      chk("mid_val", {28'd0, digit_val}, 32'h0);
      chk("mid_sel", {28'd0, digit_sel}, 32'hD);
      repeat (9) @(negedge clk);
      chk("late_val", {28'd0, digit_val}, 32'h0);
      chk("late_pending", {31'd0, pending}, 32'd1);
      wait_frame_start(n);
      chk("mid_fs_delay", n, 32'd1);
      chk("mid_commit_pending", {31'd0, pending}, 32'd0);
      check_frame("f1111", 16'h1111, 4'b1111);

      // Last load before commit wins
      repeat (2) @(negedge clk);
      load    = 1'b1;
      data_in = 16'h2222;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      load    = 1'b1;
      data_in = 16'h3333;
      @(negedge clk);
      load = 1'b0;
      chk("lw_pending", {31'd0, pending}, 32'd1);
      wait_frame_start(n);
      check_frame("f3333", 16'h3333, 4'b1111);

      // Load in the commit cycle bypasses straight to the display
      load    = 1'b1;
      data_in = 16'h5555;
      @(negedge clk);
      load = 1'b0;
      chk("byp_fs", {31'd0, frame_start}, 32'd1);
      chk("byp_val", {28'd0, digit_val}, 32'h5);
      chk("byp_pending", {31'd0, pending}, 32'd0);
      chk("byp_sel", {28'd0, digit_sel}, 32'hF);
      @(negedge clk);
      chk("byp_t1_sel", {28'd0, digit_sel}, 32'hE);
      chk("byp_t1_val", {28'd0, digit_val}, 32'h5);
      chk("byp_t1_pending", {31'd0, pending}, 32'd0);

      // Asynchronous reset during slot 2 ON
      wait_frame_start(n);
      chk("byp_next_fs_delay", n, 32'd15);
      repeat (9) @(negedge clk);
      chk("pre_rst_sel", {28'd0, digit_sel}, 32'hB);
      chk("pre_rst_val", {28'd0, digit_val}, 32'h5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sel", {28'd0, digit_sel}, 32'hF);
      chk("async_rst_val", {28'd0, digit_val}, 32'h0);
      chk("async_rst_pending", {31'd0, pending}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rel2_sel", {28'd0, digit_sel}, 32'hF);
      chk("rel2_fs", {31'd0, frame_start}, 32'd0);
      @(negedge clk);
      chk("rel2_t1_sel", {28'd0, digit_sel}, 32'hE);
      chk("rel2_t1_val", {28'd0, digit_val}, 32'h0);
      wait_frame_start(n);
      chk("rel2_fs_delay", n, 32'd15);
      chk("rel2_frame_val", {28'd0, digit_val}, 32'h0);
      chk("rel2_frame_pending", {31'd0, pending}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
